program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter AB, default 11, meaning the program memory address width in bits.
REQ-002 The block SHALL have parameter DB, default 16, meaning the instruction word width in bits; the design supports only DB=16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rx_done, input, 1 bit: one-cycle pulse marking that rx_data holds a received byte.
REQ-006 The block SHALL have port rx_data, input, 8 bits: the received byte, valid only while rx_done=1.
REQ-007 The block SHALL have port mem_we, output, 1 bit: one-cycle write strobe to program memory.
REQ-008 The block SHALL have port mem_addr, output, AB bits: the program memory write address.
REQ-009 The block SHALL have port mem_wdata, output, DB bits: the program memory write word.
REQ-010 The block SHALL have port busy, output, 1 bit: high from the first accepted byte until done or err is raised.
REQ-011 The block SHALL have port done, output, 1 bit: high once all words are written, held until reset.
REQ-012 The block SHALL have port err, output, 1 bit: high on an illegal length header, held until reset.

Function
REQ-013 Stream format SHALL be: length header N (16 bits, high byte first), then N words, each sent high byte first.
REQ-014 Legal N SHALL be 1..2^AB (1..2048 at default); N=0 or N>2^AB SHALL go to ERR with no memory write.
REQ-015 The FSM SHALL have states LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE and ERR; the reset state is LEN_HI.
REQ-016 Transitions SHALL occur only on rx_done=1: LEN_HI->LEN_LO; LEN_LO->DATA_HI if N is legal, else ERR; DATA_HI->DATA_LO; DATA_LO->DATA_HI, or DONE on the last word.
REQ-017 In DONE and ERR, rx_done SHALL be ignored; the only exit from either state is reset.
REQ-018 The internal write pointer wr_ptr (AB bits) SHALL be 0 after reset; word k SHALL be written at address k.
REQ-019 On rx_done in DATA_LO, the block SHALL register mem_we=1, mem_addr=wr_ptr and mem_wdata={held high byte, rx_data}, all visible in the next cycle (latency 1).
REQ-020 In the same cycle as REQ-019, wr_ptr SHALL increment.
REQ-021 mem_we SHALL be high for exactly one cycle per word; mem_addr and mem_wdata SHALL hold their values after the strobe.
REQ-022 The last-word test SHALL be wr_ptr == N-1, with N-1 stored in AB bits, so N=2^AB is handled without overflow; wr_ptr SHALL never wrap.
REQ-023 done SHALL rise in the same cycle as the last mem_we pulse; busy SHALL fall in that same cycle.
REQ-024 err SHALL rise in the cycle after the illegal LEN_LO byte; busy SHALL be 0 whenever err=1.
REQ-025 busy SHALL rise in the cycle after the first rx_done in LEN_HI.
REQ-026 rx_done on consecutive cycles SHALL each be accepted; no byte SHALL be dropped in any non-terminal state.

Reset
REQ-027 On reset=1 at a clock edge, state SHALL be LEN_HI and wr_ptr=0.
REQ-028 On reset, mem_we, mem_addr, mem_wdata, busy, done and err SHALL all be 0.
REQ-029 Reset SHALL take priority over rx_done in the same cycle.
REQ-030 Reset mid-stream SHALL discard any partial word; no mem_we SHALL be issued for it.

Structure
REQ-031 State encodings and the AB/DB defaults SHALL live in the shared processor constants package/include used by the program memory and the CPU.
REQ-032 The block SHALL be a single module with no sub-module; byte assembly is a one-byte holding register inside the FSM.

Verification
REQ-033 Bytes 00 02 | 03 00 | 0B 18 -> mem_we at addr 0 with 0x0300, then addr 1 with 0x0B18; done=1 with the second strobe.
REQ-034 Bytes 00 00 -> err=1 one cycle after the second byte, no mem_we, and later bytes ignored; bytes 08 01 -> same result.
REQ-035 N=2048 with word k = k -> 2048 strobes at addresses 0..2047 with data k; done at address 2047; no wrap to 0.
REQ-036 rx_done asserted every cycle for header 00 01 and word 12 34 -> single write 0x1234 at addr 0, one cycle after the 4th byte.
REQ-037 Reset after header 00 03 and one data byte AB, then stream 00 01 55 AA -> only write is 0x55AA at addr 0.
REQ-038 rx_done and reset high in the same cycle -> all outputs 0 and state LEN_HI.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared processor constants: program memory geometry and loader FSM state encodings.
package program_loader_pkg;

  localparam int PL_AB = 11;
  localparam int PL_DB = 16;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: parses a 16-bit length header, then writes N
// big-endian 16-bit words into program memory at consecutive addresses.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int AB = PL_AB,
  parameter int DB = PL_DB
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_done,
  input  logic [7:0]    rx_data,
  output logic          mem_we,
  output logic [AB-1:0] mem_addr,
  output logic [DB-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  loader_state_t r_state, w_stateNext;
  logic [7:0]    r_hold, w_holdNext;
  logic [AB-1:0] r_lenM1, w_lenM1Next;
  logic [AB-1:0] r_wrPtr, w_wrPtrNext;
  logic          r_we, w_weNext;
  logic [AB-1:0] r_addr, w_addrNext;
  logic [DB-1:0] r_wdata, w_wdataNext;
  logic          r_busy, w_busyNext;
  logic          r_done, w_doneNext;
  logic          r_err, w_errNext;

  logic [15:0]   w_len;
  logic          w_lenLegal;

  // Header is legal for 1..2^AB words; compared in 32 bits so 2^AB itself fits.
  assign w_len      = {r_hold, rx_data};
  assign w_lenLegal = (w_len != 16'd0) && ({16'd0, w_len} <= (32'd1 << AB));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LEN_HI;
      r_hold  <= '0;
      r_lenM1 <= '0;
      r_wrPtr <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_hold  <= w_holdNext;
      r_lenM1 <= w_lenM1Next;
      r_wrPtr <= w_wrPtrNext;
      r_we    <= w_weNext;
      r_addr  <= w_addrNext;
      r_wdata <= w_wdataNext;
      r_busy  <= w_busyNext;
      r_done  <= w_doneNext;
      r_err   <= w_errNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_holdNext  = r_hold;
    w_lenM1Next = r_lenM1;
    w_wrPtrNext = r_wrPtr;
    w_weNext    = 1'b0;
    w_addrNext  = r_addr;
    w_wdataNext = r_wdata;
    w_busyNext  = r_busy;
    w_doneNext  = r_done;
    w_errNext   = r_err;
    if (rx_done) begin
      case (r_state)
        LEN_HI: begin
          w_holdNext  = rx_data;
          w_busyNext  = 1'b1;
          w_stateNext = LEN_LO;
        end
        LEN_LO: begin
          if (w_lenLegal) begin
            w_lenM1Next = AB'(w_len - 16'd1);
            w_stateNext = DATA_HI;
          end else begin
            w_errNext   = 1'b1;
            w_busyNext  = 1'b0;
            w_stateNext = ERR;
          end
        end
        DATA_HI: begin
          w_holdNext  = rx_data;
          w_stateNext = DATA_LO;
        end
        DATA_LO: begin
          w_weNext    = 1'b1;
          w_addrNext  = r_wrPtr;
          w_wdataNext = DB'({r_hold, rx_data});
          // The pointer stops on the last word so a full 2^AB load never wraps it.
          if (r_wrPtr == r_lenM1) begin
            w_doneNext  = 1'b1;
            w_busyNext  = 1'b0;
            w_stateNext = DONE;
          end else begin
            w_wrPtrNext = r_wrPtr + 1'b1;
            w_stateNext = DATA_HI;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a byte-count model of the stream format checked
// every cycle, plus literal expectations for the directed streams.
module tb_program_loader;

  localparam int AB = 11;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          mem_we;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          err;

  int totalChecks = 0;
  int badChecks = 0;
  bit checking = 1'b0;

  program_loader #(.AB(AB), .DB(DB)) dut (
    .clk(clk),
    .reset(reset),
    .rx_done(rx_done),
    .rx_data(rx_data),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // Model: the stream is just a count of accepted bytes since reset. Bytes 0-1
  // form the header, every later even count completes word (count-4)/2.
  int            mCount;
  logic [7:0]    mPrev;
  int            mLen;
  logic          expWe, expBusy, expDone, expErr;
  logic [AB-1:0] expAddr;
  logic [DB-1:0] expData;
  int            mWrCount;

  always @(posedge clk) begin
    int k;
    expWe = 1'b0;
    if (reset) begin
      mCount = 0; mPrev = 8'h00; mLen = 0;
      expBusy = 1'b0; expDone = 1'b0; expErr = 1'b0;
      expAddr = '0; expData = '0;
    end else if (rx_done && !expDone && !expErr) begin
      mCount = mCount + 1;
      expBusy = 1'b1;
      if (mCount == 2) begin
        mLen = int'({mPrev, rx_data});
        if (mLen == 0 || mLen > (1 << AB)) begin
          expErr = 1'b1;
          expBusy = 1'b0;
        end
      end else if (mCount > 2 && (mCount % 2) == 0) begin
        k = (mCount - 4) / 2;
        expWe = 1'b1;
        expAddr = k[AB-1:0];
        expData = {mPrev, rx_data};
        mWrCount = mWrCount + 1;
        if (k == mLen - 1) begin
          expDone = 1'b1;
          expBusy = 1'b0;
        end
      end
      mPrev = rx_data;
    end
  end

  // Write log of what the DUT actually produced, for the literal checks.
  int            dutWrCount;
  logic [AB-1:0] dutAddrLog [$];
  logic [DB-1:0] dutDataLog [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("mem_we", 32'(mem_we), 32'(expWe));
      checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr));
      checkOutput("mem_wdata", 32'(mem_wdata), 32'(expData));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("err", 32'(err), 32'(expErr));
      if (mem_we) begin
        dutWrCount++;
        dutAddrLog.push_back(mem_addr);
        dutDataLog.push_back(mem_wdata);
      end
    end
  end

  // Drive one byte for one cycle, then idle for gap cycles; entered at posedge+1.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic clearLogs();
    dutWrCount = 0;
    mWrCount = 0;
    dutAddrLog.delete();
    dutDataLog.delete();
  endtask

  initial begin
    int addrErrs;
    clearLogs();
    @(posedge clk); #1;
    checking = 1'b1;
    checkOutput("resetWe", 32'(mem_we), 0);
    checkOutput("resetBusy", 32'(busy), 0);
    checkOutput("resetDone", 32'(done), 0);
    reset = 1'b0;

    // Two words with idle gaps between bytes.
    $display("[TB] two-word stream");
    applyStimulus(8'h00, 1); applyStimulus(8'h02, 2);
    applyStimulus(8'h03, 1); applyStimulus(8'h00, 1);
    applyStimulus(8'h0B, 1); applyStimulus(8'h18, 3);
    checkOutput("twoWrites", 32'(dutWrCount), 2);
    checkOutput("modelWrites", 32'(mWrCount), 2);
    checkOutput("w0Addr", 32'(dutAddrLog[0]), 0);
    checkOutput("w0Data", 32'(dutDataLog[0]), 32'h0300);
    checkOutput("w1Addr", 32'(dutAddrLog[1]), 1);
    checkOutput("w1Data", 32'(dutDataLog[1]), 32'h0B18);
    checkOutput("twoDone", 32'(done), 1);
    checkOutput("twoBusy", 32'(busy), 0);
    applyStimulus(8'h77, 0); applyStimulus(8'h66, 2);
    checkOutput("doneIgnores", 32'(dutWrCount), 2);

    // Zero-length header, then trailing bytes ignored.
    $display("[TB] zero header");
    doReset(); clearLogs();
    applyStimulus(8'h00, 0); applyStimulus(8'h00, 0);
    checkOutput("zeroErrLatency", 32'(err), 1);
    checkOutput("zeroBusy", 32'(busy), 0);
    applyStimulus(8'h11, 0); applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0); applyStimulus(8'h44, 2);
    checkOutput("zeroNoWrites", 32'(dutWrCount), 0);
    checkOutput("zeroErrHeld", 32'(err), 1);

    // 2049 words is one too many.
    $display("[TB] oversize header");
    doReset(); clearLogs();
    applyStimulus(8'h08, 0); applyStimulus(8'h01, 0);
    checkOutput("bigErrLatency", 32'(err), 1);
    applyStimulus(8'h12, 0); applyStimulus(8'h34, 2);
    checkOutput("bigNoWrites", 32'(dutWrCount), 0);

    // Back-to-back bytes, single word.
    $display("[TB] back-to-back");
    doReset(); clearLogs();
    applyStimulus(8'h00, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'h12, 0); applyStimulus(8'h34, 0);
    checkOutput("b2bWeLatency", 32'(mem_we), 1);
    checkOutput("b2bAddr", 32'(mem_addr), 0);
    checkOutput("b2bData", 32'(mem_wdata), 32'h1234);
    checkOutput("b2bDone", 32'(done), 1);
    @(posedge clk); #1;
    checkOutput("b2bWeOnce", 32'(mem_we), 0);
    checkOutput("b2bDataHeld", 32'(mem_wdata), 32'h1234);

    // Reset mid-word drops the partial word.
    $display("[TB] reset mid-stream");
    doReset(); clearLogs();
    applyStimulus(8'h00, 0); applyStimulus(8'h03, 1);
    applyStimulus(8'hAB, 1);
    doReset();
    applyStimulus(8'h00, 0); applyStimulus(8'h01, 1);
    applyStimulus(8'h55, 0); applyStimulus(8'hAA, 2);
    checkOutput("midWrites", 32'(dutWrCount), 1);
    checkOutput("midAddr", 32'(dutAddrLog[0]), 0);
    checkOutput("midData", 32'(dutDataLog[0]), 32'h55AA);

    // Reset wins over a simultaneous byte.
    $display("[TB] reset with rx_done");
    rx_done = 1'b1; rx_data = 8'h00; reset = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0; reset = 1'b0;
    checkOutput("rstPriBusy", 32'(busy), 0);
    checkOutput("rstPriOuts", {mem_we, done, err, 13'd0, mem_wdata}, 0);
    applyStimulus(8'h00, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'hC0, 0); applyStimulus(8'hDE, 1);
    checkOutput("rstPriWrite", 32'(mem_wdata), 32'hC0DE);

    // Full-depth load: 2048 words, word k = k.
    $display("[TB] full 2048-word load");
    doReset(); clearLogs();
    applyStimulus(8'h08, 0); applyStimulus(8'h00, 0);
    for (int k = 0; k < 2048; k++) begin
      logic [15:0] w;
      w = 16'(k);
      applyStimulus(w[15:8], 0);
      applyStimulus(w[7:0], 0);
    end
    @(posedge clk); #1;
    checkOutput("fullWrites", 32'(dutWrCount), 2048);
    checkOutput("fullDone", 32'(done), 1);
    checkOutput("fullLastAddr", 32'(dutAddrLog[2047]), 2047);
    checkOutput("fullLastData", 32'(dutDataLog[2047]), 2047);
    addrErrs = 0;
    for (int i = 0; i < dutAddrLog.size(); i++)
      if (dutAddrLog[i] != AB'(i) || dutDataLog[i] != 16'(i)) addrErrs++;
    checkOutput("fullSequence", 32'(addrErrs), 0);
    applyStimulus(8'hFF, 0); applyStimulus(8'hFF, 2);
    checkOutput("fullNoWrap", 32'(dutWrCount), 2048);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
